// File: rtl/lsu_wb_stage.sv
// lsu_wb_stage: EX->MEM/WB stage issuing data-memory requests and driving register-file writeback
module lsu_wb_stage #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          valid_in,
    input  logic [DW-1:0] alu_result_in,
    input  logic [DW-1:0] store_data_in,
    input  logic [DW-1:0] pc_plus_4_in,
    input  logic [DW-1:0] imm_in,
    input  logic [4:0]    rd_addr_in,
    input  logic [1:0]    load_size_in,
    input  logic          load_unsigned_in,
    input  logic          is_load_in,
    input  logic          is_store_in,
    input  logic [2:0]    wb_mux_sel_in,
    input  logic          rf_wr_en_in,
    output logic          dmem_req_o,
    output logic          dmem_we_o,
    output logic [AW-1:0] dmem_addr_o,
    output logic [3:0]    dmem_be_o,
    output logic [DW-1:0] dmem_wdata_o,
    input  logic          dmem_gnt_i,
    input  logic          dmem_rvalid_i,
    input  logic [DW-1:0] dmem_rdata_i,
    output logic          stall_o,
    output logic          wb_en_o,
    output logic [4:0]    wb_rd_addr_o,
    output logic [DW-1:0] wb_data_o,
    output logic          misalign_o
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, WB} state_t;

    function automatic logic [31:0] wb_mux(input logic [2:0] sel, input logic [31:0] alu, ld, pc4, imm);
        return sel == 3'b001 ? ld : sel == 3'b010 ? pc4 : sel == 3'b011 ? imm : alu;
    endfunction

    function automatic logic [31:0] ext(input logic [1:0] sz, input logic uns, input logic [1:0] a, input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(d >> {a, 3'b000});
        h = 16'(d >> {a[1], 4'b0000});
        return sz == 2'b00 ? {{24{!uns && b[7]}}, b} : sz == 2'b01 ? {{16{!uns && h[15]}}, h} : d;
    endfunction

    state_t        state_q, state_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d, store_q, store_d, wr_q, wr_d;
    logic [2:0]    sel_q, sel_d;
    logic [4:0]    rd_q, rd_d, wb_rd_q, wb_rd_d;
    logic [DW-1:0] alu_q, alu_d, pc4_q, pc4_d, imm_q, imm_d, ld_q, ld_d;
    logic          req_q, req_d, we_q, we_d, wb_en_q, wb_en_d, mis_q, mis_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [3:0]    be_q, be_d;
    logic [DW-1:0] wdata_q, wdata_d, wb_data_q, wb_data_d;
    logic          mem, mis;
    logic [DW-1:0] ld_v;

    assign mem  = is_load_in || is_store_in;
    assign mis  = (load_size_in == 2'b01 && alu_result_in[0]) || (load_size_in[1] && alu_result_in[1:0] != 2'b00);
    assign ld_v = ext(size_q, uns_q, alu_q[1:0], dmem_rdata_i);

    always_comb begin
        state_d   = state_q;
        size_d    = size_q;
        uns_d     = uns_q;
        store_d   = store_q;
        wr_d      = wr_q;
        sel_d     = sel_q;
        rd_d      = rd_q;
        alu_d     = alu_q;
        pc4_d     = pc4_q;
        imm_d     = imm_q;
        ld_d      = ld_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        wb_en_d   = 1'b0;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        mis_d     = 1'b0;
        unique case (state_q)
            IDLE: if (valid_in && !mem) begin
                if (rf_wr_en_in && rd_addr_in != 5'd0) begin
                    wb_en_d   = 1'b1;
                    wb_rd_d   = rd_addr_in;
                    wb_data_d = wb_mux(wb_mux_sel_in, alu_result_in, ld_q, pc_plus_4_in, imm_in);
                end
            end else if (valid_in) begin
                size_d  = load_size_in;
                uns_d   = load_unsigned_in;
                store_d = is_store_in && !is_load_in;
                wr_d    = rf_wr_en_in;
                sel_d   = wb_mux_sel_in;
                rd_d    = rd_addr_in;
                alu_d   = alu_result_in;
                pc4_d   = pc_plus_4_in;
                imm_d   = imm_in;
                mis_d   = mis;
                state_d = mis ? IDLE : REQ;
                req_d   = !mis;
                we_d    = is_store_in && !is_load_in;
                addr_d  = {alu_result_in[AW-1:2], 2'b00};
                be_d    = load_size_in == 2'b00 ? 4'b0001 << alu_result_in[1:0] :
                          load_size_in == 2'b01 ? 4'b0011 << alu_result_in[1:0] : 4'b1111;
                wdata_d = load_size_in == 2'b00 ? {4{store_data_in[7:0]}} :
                          load_size_in == 2'b01 ? {2{store_data_in[15:0]}} : store_data_in;
            end
            REQ: if (dmem_gnt_i) begin
                req_d   = 1'b0;
                state_d = store_q ? IDLE : RESP;
            end
            RESP: if (dmem_rvalid_i) begin
                ld_d    = ld_v;
                state_d = WB;
                if (wr_q && rd_q != 5'd0) begin
                    wb_en_d   = 1'b1;
                    wb_rd_d   = rd_q;
                    wb_data_d = wb_mux(sel_q, alu_q, ld_v, pc4_q, imm_q);
                end
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            size_q    <= '0;
            uns_q     <= 1'b0;
            store_q   <= 1'b0;
            wr_q      <= 1'b0;
            sel_q     <= '0;
            rd_q      <= '0;
            alu_q     <= '0;
            pc4_q     <= '0;
            imm_q     <= '0;
            ld_q      <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            wb_en_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            mis_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            store_q   <= store_d;
            wr_q      <= wr_d;
            sel_q     <= sel_d;
            rd_q      <= rd_d;
            alu_q     <= alu_d;
            pc4_q     <= pc4_d;
            imm_q     <= imm_d;
            ld_q      <= ld_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            wb_en_q   <= wb_en_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            mis_q     <= mis_d;
        end
    end

    assign dmem_req_o   = req_q;
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_be_o    = be_q;
    assign dmem_wdata_o = wdata_q;
    assign stall_o      = state_q != IDLE;
    assign wb_en_o      = wb_en_q;
    assign wb_rd_addr_o = wb_rd_q;
    assign wb_data_o    = wb_data_q;
    assign misalign_o   = mis_q;
endmodule

// File: tb/tb_lsu_wb_stage.sv
// tb_lsu_wb_stage: randomized and directed checks of lsu_wb_stage against a behavioural model
module tb_lsu_wb_stage;
    logic        clk_in = 1'b0, rst_in = 1'b1, valid_in = 1'b0;
    logic [31:0] alu_result_in = '0, store_data_in = '0, pc_plus_4_in = '0, imm_in = '0;
    logic [4:0]  rd_addr_in = '0;
    logic [1:0]  load_size_in = '0;
    logic        load_unsigned_in = 1'b0, is_load_in = 1'b0, is_store_in = 1'b0, rf_wr_en_in = 1'b0;
    logic [2:0]  wb_mux_sel_in = '0;
    logic        dmem_req_o, dmem_we_o, dmem_gnt_i = 1'b0, dmem_rvalid_i = 1'b0;
    logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i = '0, wb_data_o;
    logic [3:0]  dmem_be_o;
    logic        stall_o, wb_en_o, misalign_o;
    logic [4:0]  wb_rd_addr_o;
    logic [109:0] all_out;

    lsu_wb_stage dut (
        .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .alu_result_in(alu_result_in),
        .store_data_in(store_data_in), .pc_plus_4_in(pc_plus_4_in), .imm_in(imm_in),
        .rd_addr_in(rd_addr_in), .load_size_in(load_size_in), .load_unsigned_in(load_unsigned_in),
        .is_load_in(is_load_in), .is_store_in(is_store_in), .wb_mux_sel_in(wb_mux_sel_in),
        .rf_wr_en_in(rf_wr_en_in), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .stall_o(stall_o), .wb_en_o(wb_en_o), .wb_rd_addr_o(wb_rd_addr_o), .wb_data_o(wb_data_o),
        .misalign_o(misalign_o)
    );

    assign all_out = {dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o, stall_o,
                      wb_en_o, wb_rd_addr_o, wb_data_o, misalign_o};

    always #5 clk_in = ~clk_in;

    int n_cmp = 0, n_bad = 0;

    logic        op_ld, op_st, op_uns, op_wr;
    logic [1:0]  op_sz;
    logic [2:0]  op_sel;
    logic [4:0]  op_rd;
    logic [31:0] op_alu, op_sd, op_pc4, op_imm, op_rdata;
    int          op_gd, op_rvd;

    int          o_req, o_stall, o_wb, o_mis, o_wbc;
    logic        o_we, o_unstable;
    logic [3:0]  o_be;
    logic [4:0]  o_wbrd;
    logic [31:0] o_addr, o_wdata, o_wbd;

    function automatic logic [31:0] model_load();
        longint v;
        int lane = int'(op_alu % 4);
        if (op_sz == 2'd0) begin
            v = longint'((op_rdata >> (8 * lane)) % 256);
            if (!op_uns && v >= 128) v -= 256;
        end else if (op_sz == 2'd1) begin
            v = longint'((op_rdata >> (16 * (lane / 2))) % 65536);
            if (!op_uns && v >= 32768) v -= 65536;
        end else v = longint'(op_rdata);
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_wb();
        if (op_sel == 3'd1) return model_load();
        if (op_sel == 3'd2) return op_pc4;
        if (op_sel == 3'd3) return op_imm;
        return op_alu;
    endfunction

    task automatic drive_fields();
        valid_in = 1'b1; is_load_in = op_ld; is_store_in = op_st; load_size_in = op_sz;
        load_unsigned_in = op_uns; wb_mux_sel_in = op_sel; rf_wr_en_in = op_wr; rd_addr_in = op_rd;
        alu_result_in = op_alu; store_data_in = op_sd; pc_plus_4_in = op_pc4; imm_in = op_imm;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    endtask

    task automatic run_op();
        int pend = 0, rvc = 0;
        @(negedge clk_in);
        drive_fields();
        o_req = 0; o_stall = 0; o_wb = 0; o_mis = 0; o_wbc = -1; o_unstable = 1'b0;
        for (int c = 0; c < op_gd + op_rvd + 6; c++) begin
            @(negedge clk_in);
            valid_in = stall_o;
            if (stall_o) begin
                alu_result_in = $urandom; store_data_in = $urandom; rd_addr_in = 5'($urandom);
                is_load_in = 1'($urandom); is_store_in = 1'($urandom); load_size_in = 2'($urandom);
            end
            dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = $urandom;
            if (stall_o) o_stall++;
            if (misalign_o) o_mis++;
            if (wb_en_o) begin
                if (o_wb == 0) o_wbc = c;
                o_wb++; o_wbrd = wb_rd_addr_o; o_wbd = wb_data_o;
            end
            if (dmem_req_o) begin
                if (o_req == 0) begin
                    o_addr = dmem_addr_o; o_we = dmem_we_o; o_be = dmem_be_o; o_wdata = dmem_wdata_o;
                end else if ({o_addr, o_we, o_be, o_wdata} !== {dmem_addr_o, dmem_we_o, dmem_be_o, dmem_wdata_o})
                    o_unstable = 1'b1;
                dmem_rvalid_i = 1'($urandom);
                if (o_req == op_gd) begin dmem_gnt_i = 1'b1; pend = int'(!dmem_we_o); end
                o_req++;
            end else if (pend != 0) begin
                if (rvc == op_rvd) begin dmem_rvalid_i = 1'b1; dmem_rdata_i = op_rdata; pend = 0; end
                rvc++;
            end else dmem_rvalid_i = 1'($urandom);
        end
        valid_in = 1'b0; dmem_rvalid_i = 1'b0;
    endtask

    task automatic set_op(input logic ld, st, input logic [1:0] sz, input logic uns, input logic [2:0] sel,
                          input logic [4:0] rd, input logic [31:0] alu, sd, rdata, input int gd);
        op_ld = ld; op_st = st; op_sz = sz; op_uns = uns; op_sel = sel; op_wr = 1'b1; op_rd = rd;
        op_alu = alu; op_sd = sd; op_rdata = rdata; op_pc4 = 32'h0000_0104; op_imm = 32'h0001_2000;
        op_gd = gd; op_rvd = 0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (all_out !== '0) begin n_bad++; $display("FAIL reset_outputs: got %h expected 0", all_out); end
        repeat (2) @(negedge clk_in);
        n_cmp++; if (all_out !== '0) begin n_bad++; $display("FAIL reset_held: got %h expected 0", all_out); end
        rst_in = 1'b0;
    endtask

    task automatic test_alu();
        set_op(1'b0, 1'b0, 2'd2, 1'b0, 3'd0, 5'd5, 32'h1234_5678, 32'h0, 32'h0, 0);
        run_op();
        n_cmp++; if (o_wb !== 1 || o_wbc !== 0) begin n_bad++; $display("FAIL alu_wb: got count %0d cycle %0d expected 1 at 0", o_wb, o_wbc); end
        n_cmp++; if (o_wbrd !== 5'd5 || o_wbd !== 32'h1234_5678) begin n_bad++; $display("FAIL alu_data: got rd %0d data %h expected rd 5 data 12345678", o_wbrd, o_wbd); end
        n_cmp++; if (o_stall !== 0 || o_req !== 0) begin n_bad++; $display("FAIL alu_stall: got stall %0d req %0d expected 0 0", o_stall, o_req); end
    endtask

    task automatic test_lb();
        set_op(1'b1, 1'b0, 2'd0, 1'b0, 3'd1, 5'd7, 32'h0000_1003, 32'h0, 32'h80FF_FF7F, 0);
        run_op();
        n_cmp++; if (o_addr !== 32'h1000 || o_we !== 1'b0) begin n_bad++; $display("FAIL lb_addr: got %h we %b expected 1000 we 0", o_addr, o_we); end
        n_cmp++; if (o_wb !== 1 || o_wbd !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_signed: got %0d/%h expected 1/ffffff80", o_wb, o_wbd); end
        n_cmp++; if (o_stall !== 3 || o_wbc !== 2) begin n_bad++; $display("FAIL lb_latency: got stall %0d wb cycle %0d expected 3 and 2", o_stall, o_wbc); end
        op_uns = 1'b1;
        run_op();
        n_cmp++; if (o_wb !== 1 || o_wbd !== 32'h0000_0080) begin n_bad++; $display("FAIL lbu: got %0d/%h expected 1/00000080", o_wb, o_wbd); end
    endtask

    task automatic test_sh();
        set_op(1'b0, 1'b1, 2'd1, 1'b0, 3'd0, 5'd3, 32'h0000_2002, 32'h5555_ABCD, 32'h0, 2);
        run_op();
        n_cmp++; if (o_req !== 3 || o_unstable !== 1'b0) begin n_bad++; $display("FAIL sh_req: got %0d cycles unstable %b expected 3 stable", o_req, o_unstable); end
        n_cmp++; if (o_be !== 4'b1100 || o_wdata !== 32'hABCD_ABCD || o_we !== 1'b1) begin n_bad++; $display("FAIL sh_lanes: got be %b wdata %h we %b expected 1100 abcdabcd 1", o_be, o_wdata, o_we); end
        n_cmp++; if (o_addr !== 32'h2000 || o_stall !== 3 || o_wb !== 0) begin n_bad++; $display("FAIL sh_misc: got addr %h stall %0d wb %0d expected 2000 3 0", o_addr, o_stall, o_wb); end
    endtask

    task automatic test_misalign();
        set_op(1'b1, 1'b0, 2'd2, 1'b0, 3'd1, 5'd4, 32'h0000_3001, 32'h0, 32'h0, 0);
        run_op();
        n_cmp++; if (o_mis !== 1 || o_req !== 0 || o_wb !== 0 || o_stall !== 0) begin n_bad++; $display("FAIL misalign: got mis %0d req %0d wb %0d stall %0d expected 1 0 0 0", o_mis, o_req, o_wb, o_stall); end
    endtask

    task automatic test_rd0();
        set_op(1'b1, 1'b0, 2'd2, 1'b0, 3'd1, 5'd0, 32'h0000_4000, 32'h0, 32'hDEAD_BEEF, 0);
        run_op();
        n_cmp++; if (o_req !== 1 || o_stall !== 3 || o_wb !== 0) begin n_bad++; $display("FAIL rd0: got req %0d stall %0d wb %0d expected 1 3 0", o_req, o_stall, o_wb); end
    endtask

    task automatic test_reset_mid();
        int wbs = 0;
        set_op(1'b1, 1'b0, 2'd2, 1'b0, 3'd1, 5'd9, 32'h0000_5000, 32'h0, 32'h0, 0);
        @(negedge clk_in); drive_fields();
        @(negedge clk_in); valid_in = 1'b0;
        n_cmp++; if (dmem_req_o !== 1'b1) begin n_bad++; $display("FAIL mid_req: got %b expected 1", dmem_req_o); end
        dmem_gnt_i = 1'b1;
        @(negedge clk_in); dmem_gnt_i = 1'b0;
        n_cmp++; if (stall_o !== 1'b1 || dmem_req_o !== 1'b0) begin n_bad++; $display("FAIL mid_resp: got stall %b req %b expected 1 0", stall_o, dmem_req_o); end
        #2 rst_in = 1'b1;
        #1;
        n_cmp++; if (all_out !== '0) begin n_bad++; $display("FAIL mid_reset_outputs: got %h expected 0", all_out); end
        @(negedge clk_in); rst_in = 1'b0;
        for (int c = 0; c < 4; c++) begin
            dmem_rvalid_i = 1'b1; dmem_rdata_i = $urandom;
            @(negedge clk_in);
            if (wb_en_o) wbs++;
        end
        dmem_rvalid_i = 1'b0;
        n_cmp++; if (wbs !== 0 || stall_o !== 1'b0) begin n_bad++; $display("FAIL late_rvalid: got wb %0d stall %b expected 0 0", wbs, stall_o); end
        set_op(1'b0, 1'b1, 2'd2, 1'b0, 3'd0, 5'd1, 32'h0000_6000, 32'h1111_2222, 32'h0, 0);
        @(negedge clk_in); drive_fields();
        @(negedge clk_in); valid_in = 1'b0;
        #2 rst_in = 1'b1;
        #1;
        n_cmp++; if (dmem_req_o !== 1'b0 || stall_o !== 1'b0) begin n_bad++; $display("FAIL req_reset: got req %b stall %b expected 0 0", dmem_req_o, stall_o); end
        @(negedge clk_in); rst_in = 1'b0;
    endtask

    task automatic rand_op();
        int k = int'($urandom_range(0, 3));
        op_ld = (k == 1 || k == 3); op_st = (k == 2 || k == 3);
        op_sz = 2'($urandom_range(0, 3)); op_uns = 1'($urandom_range(0, 1));
        op_sel = 3'($urandom_range(0, 7));
        if (k == 0 && op_sel == 3'd1) op_sel = 3'd0;
        op_wr = ($urandom_range(0, 3) != 0);
        op_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        op_alu = $urandom;
        if ($urandom_range(0, 3) != 0) op_alu = op_alu - (op_sz == 2'd0 ? 0 : op_sz == 2'd1 ? op_alu % 2 : op_alu % 4);
        op_sd = $urandom; op_pc4 = $urandom; op_imm = $urandom; op_rdata = $urandom;
        op_gd = int'($urandom_range(0, 3)); op_rvd = int'($urandom_range(0, 3));
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            logic mem, mis;
            int e_req, e_stall, e_wb, e_wbc;
            rand_op();
            run_op();
            mem = op_ld || op_st;
            mis = mem && ((op_sz == 2'd1 && op_alu % 2 != 0) || (op_sz >= 2'd2 && op_alu % 4 != 0));
            e_req = (mem && !mis) ? op_gd + 1 : 0;
            e_stall = (!mem || mis) ? 0 : op_ld ? op_gd + op_rvd + 3 : op_gd + 1;
            e_wb = (mis || (mem && !op_ld) || !op_wr || op_rd == 5'd0) ? 0 : 1;
            e_wbc = mem ? op_gd + op_rvd + 2 : 0;
            n_cmp++; if (o_req !== e_req) begin n_bad++; $display("FAIL rnd%0d req_cycles: got %0d expected %0d", i, o_req, e_req); end
            n_cmp++; if (o_stall !== e_stall) begin n_bad++; $display("FAIL rnd%0d stall_cycles: got %0d expected %0d", i, o_stall, e_stall); end
            n_cmp++; if (o_mis !== int'(mis)) begin n_bad++; $display("FAIL rnd%0d misalign: got %0d expected %0d", i, o_mis, mis); end
            n_cmp++; if (o_wb !== e_wb) begin n_bad++; $display("FAIL rnd%0d wb_count: got %0d expected %0d", i, o_wb, e_wb); end
            if (e_req > 0) begin
                n_cmp++; if (o_addr !== op_alu - op_alu % 4 || o_we !== !op_ld || o_unstable !== 1'b0) begin
                    n_bad++; $display("FAIL rnd%0d request: got addr %h we %b unstable %b expected %h %b 0", i, o_addr, o_we, o_unstable, op_alu - op_alu % 4, !op_ld);
                end
            end
            if (e_req > 0 && !op_ld) begin
                logic [3:0]  e_be;
                logic [31:0] e_wd;
                e_be = op_sz == 2'd0 ? 4'(1 << (op_alu % 4)) : op_sz == 2'd1 ? 4'(3 << (op_alu % 4)) : 4'd15;
                e_wd = op_sz == 2'd0 ? (op_sd % 256) * 32'h0101_0101 : op_sz == 2'd1 ? (op_sd % 65536) * 32'h0001_0001 : op_sd;
                n_cmp++; if (o_be !== e_be || o_wdata !== e_wd) begin n_bad++; $display("FAIL rnd%0d store_lanes: got be %b wdata %h expected %b %h", i, o_be, o_wdata, e_be, e_wd); end
            end
            if (e_wb == 1) begin
                n_cmp++; if (o_wbrd !== op_rd || o_wbd !== model_wb() || o_wbc !== e_wbc) begin
                    n_bad++; $display("FAIL rnd%0d wb_value: got rd %0d data %h cycle %0d expected %0d %h %0d", i, o_wbrd, o_wbd, o_wbc, op_rd, model_wb(), e_wbc);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_alu();
        test_lb();
        test_sh();
        test_misalign();
        test_rd0();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
